game_flow_sequencer: RTL

//  Top-level game-flow controller for the platformer: sequences title, level-intro banner, play,

---
 rtl/game_pkg.sv | 40 ++++
 rtl/key_press_detect.sv | 28 ++
 rtl/game_flow_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the platformer game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE    = 3'd0,
    BANNER   = 3'd1,
    PLAY     = 3'd2,
    PAUSE    = 3'd3,
    DYING    = 3'd4,
    GAMEOVER = 3'd5,
    WIN      = 3'd6
  } game_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

  typedef struct packed {
    logic title;
    logic banner;
    logic play;
    logic paused;
    logic dying;
    logic game_over;
    logic win;
  } game_flags_t;

  function automatic game_flags_t flags_of(input game_state_t s);
    game_flags_t f;
    f           = '0;
    f.title     = (s == TITLE);
    f.banner    = (s == BANNER);
    f.play      = (s == PLAY);
    f.paused    = (s == PAUSE);
    f.dying     = (s == DYING);
    f.game_over = (s == GAMEOVER);
    f.win       = (s == WIN);
    return f;
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Registered one-cycle press pulse for a HID key seen in either keycode slot.
module key_press_detect
  import game_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_ENTER
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  output logic        press
);

  logic hit;
  logic hit_q;

  assign hit = (keycode[15:8] == KEY) | (keycode[7:0] == KEY);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_q <= 1'b0;
      press <= 1'b0;
    end else begin
      hit_q <= hit;
      press <= hit & ~hit_q;
    end
  end

endmodule

// File: rtl/game_flow_sequencer.sv
// Game-flow FSM: title, banner, play, pause, death/respawn, game-over and win.
module game_flow_sequencer
  import game_pkg::*;
#(
  parameter logic [7:0]  START_KEY      = KEY_ENTER,
  parameter logic [7:0]  PAUSE_KEY      = KEY_P,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned LEVEL_TIME     = 400,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned BANNER_FRAMES  = 120,
  parameter int unsigned DEATH_FRAMES   = 90,
  parameter int unsigned END_X          = 980
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [10:0] x_offset,
  input  logic        player_dead,
  output logic        title,
  output logic        banner,
  output logic        play,
  output logic        paused,
  output logic        dying,
  output logic        game_over,
  output logic        DJ,
  output logic        respawn,
  output logic [1:0]  lives,
  output logic [9:0]  time_left
);

  localparam int unsigned SEC_W = $clog2(FRAMES_PER_SEC + 1);

  game_state_t       state;
  game_flags_t       flags;
  logic [6:0]        frame_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic              start_press;
  logic              pause_press;
  logic [9:0]        world_x;
  logic              unused_x_lsb;

  assign world_x      = x_offset[10:1];
  assign unused_x_lsb = x_offset[0];

  key_press_detect #(.KEY(START_KEY)) u_start (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (start_press)
  );

  key_press_detect #(.KEY(PAUSE_KEY)) u_pause (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (pause_press)
  );

  // Flags are updated alongside the state so every screen strobe is a register.
  task automatic go(input game_state_t s);
    state     <= s;
    flags     <= flags_of(s);
    frame_cnt <= '0;
    if (s == BANNER) sec_cnt <= '0;
  endtask

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= TITLE;
      flags     <= flags_of(TITLE);
      respawn   <= 1'b0;
      lives     <= '0;
      time_left <= '0;
      frame_cnt <= '0;
      sec_cnt   <= '0;
    end else begin
      respawn <= 1'b0;
      case (state)
        TITLE: begin
          if (start_press) begin
            lives     <= 2'(LIVES_INIT);
            time_left <= 10'(LEVEL_TIME);
            respawn   <= 1'b1;
            go(BANNER);
          end
        end
        BANNER: begin
          if (frame_tick) begin
            if (frame_cnt == 7'(BANNER_FRAMES - 1)) go(PLAY);
            else frame_cnt <= frame_cnt + 7'd1;
          end
        end
        PLAY: begin
          if (world_x >= 10'(END_X)) go(WIN);
          else if (player_dead || time_left == '0) go(DYING);
          else if (pause_press) go(PAUSE);
          else if (frame_tick) begin
            if (sec_cnt == SEC_W'(FRAMES_PER_SEC - 1)) begin
              sec_cnt <= '0;
              if (time_left != '0) time_left <= time_left - 10'd1;
            end else begin
              sec_cnt <= sec_cnt + SEC_W'(1);
            end
          end
        end
        PAUSE: begin
          if (pause_press) go(PLAY);
        end
        DYING: begin
          if (frame_tick) begin
            if (frame_cnt == 7'(DEATH_FRAMES - 1)) begin
              if (lives == 2'd1) begin
                lives <= '0;
                go(GAMEOVER);
              end else begin
                lives     <= lives - 2'd1;
                time_left <= 10'(LEVEL_TIME);
                respawn   <= 1'b1;
                go(BANNER);
              end
            end else begin
              frame_cnt <= frame_cnt + 7'd1;
            end
          end
        end
        GAMEOVER, WIN: begin
          if (start_press) go(TITLE);
        end
        default: go(TITLE);
      endcase
    end
  end

  assign title     = flags.title;
  assign banner    = flags.banner;
  assign play      = flags.play;
  assign paused    = flags.paused;
  assign dying     = flags.dying;
  assign game_over = flags.game_over;
  assign DJ        = flags.win;

endmodule
